mesh_router_param: RTL and testbench
====================================

# mesh_router_param

Parametrised five-port input-buffered 2D-mesh router: one FIFO per input, XY dimension-order route computation on each FIFO head, per-output round-robin arbitration and a crossbar with valid/enable flow control on every port. It is the router tile instantiated at every (X_LOC, Y_LOC) of an X_NODES×Y_NODES mesh. Packet width, buffer depth and mesh size are all parameters. An optional registered output stage is available.

## Interface
- X_NODES, 4, mesh columns (≥2)
- Y_NODES, 4, mesh rows (≥2)
- X_LOC, 0, this router's column (0..X_NODES-1)
- Y_LOC, 0, this router's row (0..Y_NODES-1)
- DATA_W, 64, packet width; dest_x = data[X_W-1:0], dest_y = data[X_W+Y_W-1:X_W], X_W = max(1,$clog2(X_NODES)), Y_W likewise
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, ≥2)
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- i_data  in  DATA_W×[0:4]  upstream packets [core, north, east, south, west]
- i_data_val  in  1×[0:4]  upstream valid
- o_en  out  1×[0:4]  upstream enable (input FIFO not full)
- o_data  out  DATA_W×[0:4]  downstream packets, same port order
- o_data_val  out  1×[0:4]  downstream valid
- i_en  in  1×[0:4]  downstream enable

## Operation
- Push on input p when i_data_val[p] & o_en[p]. Valid while o_en[p]=0 is ignored; the packet is lost and this is an upstream protocol error.
- FIFO is first-word-fall-through. The head is visible the cycle after the write.
- Route (XY): dest_x>X_LOC→east(2); dest_x<X_LOC→west(4); else dest_y<Y_LOC→north(1); dest_y>Y_LOC→south(3); else core(0). Y increases southward.
- Off-mesh redirect: a route that leaves the mesh (e.g. west at X_LOC=0, or dest beyond X_NODES-1/Y_NODES-1) is redirected to core(0).
- Each non-empty input requests exactly one output.
- Output o arbitrates only when it can accept a packet. Without the output stage this means i_en[o]=1; with it, the output register is empty or draining.
- Round-robin per output. Priority starts at ptr[o]. After a grant to input k, ptr[o] ← (k+1) mod 5. No grant leaves ptr unchanged.
- Granted input pops in the same cycle. Up to 5 transfers per cycle (a permutation).
- U-turns (e.g. east→east) are never generated by valid XY traffic. If requested, they are arbitrated normally.

## Timing
- Reset (synchronous): FIFOs empty; all ptr=0; o_data_val=0; o_data=0; o_en=0 while reset is high, 1 from the first cycle after.
- o_en[p] = (count[p] != FIFO_DEPTH), from registered count. A pop does not re-enable push in the same cycle (no bypass).
- Latency, no output stage: push at edge t → o_data/o_data_val combinational in cycle t+1 if granted. Transfer completes when o_data_val & i_en.
- Latency, output stage: +1 cycle.
- Full FIFO: o_en=0; same-cycle pop gives o_en=1 next cycle.
- Empty FIFO: no request; push and pop of the same packet in one cycle is impossible.
- Ungranted output: o_data_val=0 and o_data=0.
- Reset mid-operation: all buffered and in-flight packets are discarded.

## Configuration
- MESH_ROUTER_OUTREG_EN defined: each output has a one-entry register.
  - Loads when empty or when (o_data_val & i_en).
  - Holds o_data/o_data_val stable until i_en.
  - Arbitration is gated by register availability, not i_en.
- Undefined: the crossbar drives the outputs combinationally. Grant requires i_en[o]=1, so o_data_val never asserts against i_en=0.

## Structure
- Package mesh_router_pkg: port index constants PORT_CORE..PORT_WEST (0..4), RADIX=5, route-request typedef logic [0:4], width helper for X_W/Y_W.
- Sub-module mesh_rr_arbiter: 5-request round-robin arbiter with pointer, advance-on-grant input, one-hot grant. Instanced once per output.
- FIFOs, route compute and crossbar are inline.

## Test plan
Parameters: X_NODES=Y_NODES=4, X_LOC=Y_LOC=1, DATA_W=64, FIFO_DEPTH=4, i_en=1 unless stated.
- Routing: core input with dest (3,1)→east; (0,1)→west; (1,0)→north; (1,3)→south; (1,1)→core. Each appears exactly one cycle after the push (two with OUTREG_EN), payload intact.
- Off-mesh redirect: at X_LOC=0, dest_x=0, dest_y=0, Y_LOC=0, dest_y=7 (beyond Y_NODES-1) → delivered on core.
- Backpressure: i_en[2]=0, push 5 packets east on core → o_en[0] low after 4 accepted. Release i_en → 4 packets in order, o_en high the cycle after the first pop.
- Fairness: north, south and west all stream to east continuously → grants rotate N,S,W,N… Each input gets exactly 1/3 of 30 cycles (±1).
- Parallelism: core→east, east→west, north→south, south→core in one cycle → all four o_data_val high in the same cycle.
- Reset mid-traffic: reset asserted with 3 packets buffered → next cycle o_data_val=0, o_en=0. After release, o_en=1, no stale packets emerge.

Source files
------------

// File: rtl/mesh_router_pkg.sv
// mesh_router_pkg
//   Shared definitions for the mesh router tile: port numbering, radix,
//   the one-hot route/request vector type and the coordinate-width helper.
//   Port order everywhere: 0 core, 1 north, 2 east, 3 south, 4 west.
package mesh_router_pkg;

   localparam int unsigned RADIX      = 5;
   localparam int unsigned PORT_CORE  = 0;
   localparam int unsigned PORT_NORTH = 1;
   localparam int unsigned PORT_EAST  = 2;
   localparam int unsigned PORT_SOUTH = 3;
   localparam int unsigned PORT_WEST  = 4;

   // Bit i set = request/route toward port i.
   typedef logic [0:4] route_req_t;

   // Width of a coordinate field for a mesh dimension of 'nodes' routers.
   function automatic int unsigned coord_w(input int unsigned nodes);
      return (nodes > 2) ? $clog2(nodes) : 1;
   endfunction

endpackage

// File: rtl/mesh_rr_arbiter.sv
// mesh_rr_arbiter
//   Five-request round-robin arbiter. Priority starts at the stored pointer;
//   after a grant to input k the pointer moves to (k+1) mod 5. No grant
//   leaves the pointer unchanged.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (pointer -> 0)
//   en     in   output can accept a packet; when low nothing is granted
//   req    in   request vector, bit i = input i
//   grant  out  one-hot grant (all zero when no request or en low)
import mesh_router_pkg::*;

module mesh_rr_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  route_req_t req,
   output route_req_t grant
);

   logic [2:0]  ptr;
   logic [2:0]  nxt_ptr;
   logic        found;
   int unsigned idx;

   always_comb begin
      grant   = '0;
      nxt_ptr = ptr;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < RADIX; i++) begin
         idx = (32'(ptr) + i) % RADIX;
         if (en && !found && req[idx[2:0]]) begin
            found             = 1'b1;
            grant[idx[2:0]]   = 1'b1;
            nxt_ptr           = 3'((idx + 1) % RADIX);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= nxt_ptr;
      end
   end

endmodule

// File: rtl/mesh_router_param.sv
// mesh_router_param
//   Five-port input-buffered 2D-mesh router tile for position (X_LOC, Y_LOC)
//   of an X_NODES x Y_NODES mesh. One first-word-fall-through FIFO per input,
//   XY dimension-order routing on each FIFO head, round-robin arbitration per
//   output and a crossbar. Destinations outside the mesh are delivered to core.
//   Packet: dest_x = data[X_W-1:0], dest_y = data[X_W+Y_W-1:X_W].
// Optional build macro:
//   MESH_ROUTER_OUTREG_EN  one-entry register on every output (+1 cycle);
//                          arbitration then depends on register availability.
// Ports (arrays indexed core, north, east, south, west):
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   i_data      in   upstream packets
//   i_data_val  in   upstream valid
//   o_en        out  upstream enable (input FIFO not full)
//   o_data      out  downstream packets (zero when not valid)
//   o_data_val  out  downstream valid
//   i_en        in   downstream enable
import mesh_router_pkg::*;

module mesh_router_param #(
   parameter int unsigned X_NODES    = 4,
   parameter int unsigned Y_NODES    = 4,
   parameter int unsigned X_LOC      = 0,
   parameter int unsigned Y_LOC      = 0,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_data     [0:4],
   input  logic              i_data_val [0:4],
   output logic              o_en       [0:4],
   output logic [DATA_W-1:0] o_data     [0:4],
   output logic              o_data_val [0:4],
   input  logic              i_en       [0:4]
);

   localparam int unsigned X_W   = coord_w(X_NODES);
   localparam int unsigned Y_W   = coord_w(Y_NODES);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem     [0:4][0:FIFO_DEPTH-1];
   logic [PTR_W-1:0]  wr_ptr  [0:4];
   logic [PTR_W-1:0]  rd_ptr  [0:4];
   logic [CNT_W-1:0]  count   [0:4];
   logic [DATA_W-1:0] head    [0:4];
   logic [RADIX-1:0]  push;
   logic [RADIX-1:0]  pop;
   logic [RADIX-1:0]  has_pkt;
   logic [RADIX-1:0]  arb_en;
   route_req_t        route_oh [0:4];
   route_req_t        arb_req  [0:4];
   route_req_t        arb_gnt  [0:4];
   logic [DATA_W-1:0] xbar_data [0:4];
   logic [RADIX-1:0]  xbar_val;

   // XY routing; anything addressed outside the mesh is handed to core.
   function automatic route_req_t xy_route(input logic [DATA_W-1:0] pkt);
      route_req_t  r;
      int unsigned dx;
      int unsigned dy;
      dx = 32'(pkt[X_W-1:0]);
      dy = 32'(pkt[X_W+Y_W-1:X_W]);
      r  = '0;
      if (dx >= X_NODES || dy >= Y_NODES) r[PORT_CORE]  = 1'b1;
      else if (dx > X_LOC)                r[PORT_EAST]  = 1'b1;
      else if (dx < X_LOC)                r[PORT_WEST]  = 1'b1;
      else if (dy < Y_LOC)                r[PORT_NORTH] = 1'b1;
      else if (dy > Y_LOC)                r[PORT_SOUTH] = 1'b1;
      else                                r[PORT_CORE]  = 1'b1;
      return r;
   endfunction

   // Enable comes from the registered count only, so a pop never re-opens
   // the FIFO within the same cycle.
   always_comb begin
      for (int unsigned p = 0; p < RADIX; p++) begin
         o_en[p]     = ~reset & (count[p] != FULL_CNT);
         push[p]     = i_data_val[p] & o_en[p];
         has_pkt[p]  = ~reset & (count[p] != '0);
         head[p]     = mem[p][rd_ptr[p]];
         route_oh[p] = xy_route(head[p]);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < RADIX; p++) begin
         if (push[p]) mem[p][wr_ptr[p]] <= i_data[p];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned p = 0; p < RADIX; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            count[p]  <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < RADIX; p++) begin
            if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
            if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
            case ({push[p], pop[p]})
               2'b10:   count[p] <= count[p] + CNT_W'(1);
               2'b01:   count[p] <= count[p] - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   // Transpose per-input routes into per-output request vectors.
   always_comb begin
      for (int unsigned o = 0; o < RADIX; o++) begin
         for (int unsigned p = 0; p < RADIX; p++) begin
            arb_req[o][p] = has_pkt[p] & route_oh[p][o];
         end
      end
   end

   for (genvar g = 0; g < RADIX; g++) begin : g_arb
      mesh_rr_arbiter u_arb (
         .clk   (clk),
         .reset (reset),
         .en    (arb_en[g]),
         .req   (arb_req[g]),
         .grant (arb_gnt[g])
      );
   end

   // Each input requests one output, so an input is granted at most once.
   always_comb begin
      pop = '0;
      for (int unsigned o = 0; o < RADIX; o++) begin
         xbar_data[o] = '0;
         xbar_val[o]  = |arb_gnt[o];
         for (int unsigned p = 0; p < RADIX; p++) begin
            if (arb_gnt[o][p]) begin
               xbar_data[o] = xbar_data[o] | head[p];
               pop[p]       = 1'b1;
            end
         end
      end
   end

`ifdef MESH_ROUTER_OUTREG_EN
   logic [DATA_W-1:0] out_data [0:4];
   logic [RADIX-1:0]  out_val;

   // Register may load when empty or when its current packet is leaving.
   always_comb begin
      for (int unsigned o = 0; o < RADIX; o++) begin
         arb_en[o]     = ~out_val[o] | i_en[o];
         o_data[o]     = out_data[o];
         o_data_val[o] = out_val[o];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned o = 0; o < RADIX; o++) begin
            out_val[o]  <= 1'b0;
            out_data[o] <= '0;
         end
      end else begin
         for (int unsigned o = 0; o < RADIX; o++) begin
            if (arb_en[o]) begin
               out_val[o]  <= xbar_val[o];
               out_data[o] <= xbar_data[o];
            end
         end
      end
   end
`else
   always_comb begin
      for (int unsigned o = 0; o < RADIX; o++) begin
         arb_en[o]     = i_en[o];
         o_data[o]     = xbar_data[o];
         o_data_val[o] = xbar_val[o];
      end
   end
`endif

endmodule

// File: tb/tb_mesh_router_param.sv
module tb_mesh_router_param;

`ifdef MESH_ROUTER_OUTREG_EN
   localparam int  LAT    = 2;
   localparam bit  OUTREG = 1'b1;
`else
   localparam int  LAT    = 1;
   localparam bit  OUTREG = 1'b0;
`endif

   typedef struct {
      logic [63:0] data;
      int          cyc;
      bit          chk_lat;
   } sb_t;

   typedef struct {
      int dut;
      int src;
      int dx;
      int dy;
      int exp_port;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   // DUT A: 4x4 mesh, router at (1,1)
   logic [63:0] i_data     [0:4];
   logic        i_data_val [0:4];
   logic        o_en       [0:4];
   logic [63:0] o_data     [0:4];
   logic        o_data_val [0:4];
   logic        i_en       [0:4];

   // DUT B: 3x5 mesh, router at (0,0), 16-bit packets
   logic [15:0] b_i_data     [0:4];
   logic        b_i_data_val [0:4];
   logic        b_o_en       [0:4];
   logic [15:0] b_o_data     [0:4];
   logic        b_o_data_val [0:4];
   logic        b_i_en       [0:4];

   sb_t  sbq_a [0:4][$];
   sb_t  sbq_b [0:4][$];
   int   fair_src [$];
   vec_t vecs [0:14];

   int cyc    = 0;
   int checks = 0;
   int passes = 0;
   bit sb_on  = 1'b1;
   bit fair_on = 1'b0;

   always #5 clk = ~clk;

   mesh_router_param #(
      .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .DATA_W(64), .FIFO_DEPTH(4)
   ) dut_a (
      .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
      .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en)
   );

   mesh_router_param #(
      .X_NODES(3), .Y_NODES(5), .X_LOC(0), .Y_LOC(0), .DATA_W(16), .FIFO_DEPTH(4)
   ) dut_b (
      .clk(clk), .reset(reset), .i_data(b_i_data), .i_data_val(b_i_data_val), .o_en(b_o_en),
      .o_data(b_o_data), .o_data_val(b_o_data_val), .i_en(b_i_en)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [4:0] pk(input logic v [0:4]);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[i] = v[i];
      return r;
   endfunction

   function automatic logic [63:0] mk_a(input int dx, input int dy, input logic [31:0] tag);
      logic [1:0] x2;
      logic [1:0] y2;
      x2 = dx[1:0];
      y2 = dy[1:0];
      return (64'(tag) << 4) | (64'(y2) << 2) | 64'(x2);
   endfunction

   function automatic logic [15:0] mk_b(input int dx, input int dy, input logic [31:0] tag);
      logic [1:0]  x2;
      logic [2:0]  y3;
      logic [10:0] t11;
      x2  = dx[1:0];
      y3  = dy[2:0];
      t11 = tag[10:0];
      return (16'(t11) << 5) | (16'(y3) << 2) | 16'(x2);
   endfunction

   task automatic cmp_out(input int dut, input int port, input logic [63:0] data);
      sb_t e;
      if (dut == 0 && sbq_a[port].size() == 0) begin
         check($sformatf("unexpected_a_port%0d", port), data, 64'h0 - 64'h1);
      end else if (dut == 1 && sbq_b[port].size() == 0) begin
         check($sformatf("unexpected_b_port%0d", port), data, 64'h0 - 64'h1);
      end else begin
         if (dut == 0) e = sbq_a[port].pop_front();
         else          e = sbq_b[port].pop_front();
         check($sformatf("data_%0d_port%0d", dut, port), data, e.data);
         if (e.chk_lat) check($sformatf("latency_%0d_port%0d", dut, port), 64'(cyc), 64'(e.cyc));
      end
   endtask

   task automatic monitor();
      for (int o = 0; o < 5; o++) begin
         if (o_data_val[o] && i_en[o]) begin
            if (fair_on && o == 2) fair_src.push_back(int'(o_data[o] >> 4));
            else if (sb_on) cmp_out(0, o, o_data[o]);
         end
         if (b_o_data_val[o] && b_i_en[o] && sb_on) cmp_out(1, o, 64'(b_o_data[o]));
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic clear();
      for (int p = 0; p < 5; p++) begin
         i_data_val[p]   = 1'b0;
         b_i_data_val[p] = 1'b0;
      end
   endtask

   task automatic send(input int dut, input int src, input int dx, input int dy,
                       input int exp_port, input bit expect_it, input bit chk,
                       input logic [31:0] tag);
      sb_t e;
      if (dut == 0) begin
         i_data[src]     = mk_a(dx, dy, tag);
         i_data_val[src] = 1'b1;
         e.data = i_data[src];
      end else begin
         b_i_data[src]     = mk_b(dx, dy, tag);
         b_i_data_val[src] = 1'b1;
         e.data = 64'(b_i_data[src]);
      end
      e.cyc     = cyc + LAT;
      e.chk_lat = chk;
      if (expect_it) begin
         if (dut == 0) sbq_a[exp_port].push_back(e);
         else          sbq_b[exp_port].push_back(e);
      end
   endtask

   function automatic bit sb_empty();
      for (int p = 0; p < 5; p++)
         if (sbq_a[p].size() != 0 || sbq_b[p].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input int max_cyc);
      for (int k = 0; k < max_cyc && !sb_empty(); k++) step();
      step();
   endtask

   initial begin
      logic [4:0] exp_vec;
      logic [63:0] any_data;
      int n1, n3, n4, rot_err, win, prev, nxt;

      vecs[0]  = '{0, 0, 3, 1, 2};
      vecs[1]  = '{0, 0, 0, 1, 4};
      vecs[2]  = '{0, 0, 1, 0, 1};
      vecs[3]  = '{0, 0, 1, 3, 3};
      vecs[4]  = '{0, 0, 1, 1, 0};
      vecs[5]  = '{0, 1, 2, 2, 2};
      vecs[6]  = '{0, 4, 1, 2, 3};
      vecs[7]  = '{0, 2, 1, 0, 1};
      vecs[8]  = '{0, 3, 0, 3, 4};
      vecs[9]  = '{1, 0, 3, 0, 0};
      vecs[10] = '{1, 0, 0, 7, 0};
      vecs[11] = '{1, 0, 0, 0, 0};
      vecs[12] = '{1, 0, 1, 0, 2};
      vecs[13] = '{1, 0, 0, 2, 3};
      vecs[14] = '{1, 2, 2, 6, 0};

      reset = 1'b1;
      for (int p = 0; p < 5; p++) begin
         i_data[p] = '0; b_i_data[p] = '0;
         i_en[p] = 1'b1; b_i_en[p] = 1'b1;
      end
      clear();

      // Reset state
      step(); step();
      check("reset_o_en_a", 64'(pk(o_en)), 64'h0);
      check("reset_o_en_b", 64'(pk(b_o_en)), 64'h0);
      reset = 1'b0;
      step();
      check("post_reset_o_en_a", 64'(pk(o_en)), 64'h1f);
      check("post_reset_o_en_b", 64'(pk(b_o_en)), 64'h1f);
      check("post_reset_val_a", 64'(pk(o_data_val)), 64'h0);
      any_data = '0;
      for (int p = 0; p < 5; p++) any_data = any_data | o_data[p];
      check("post_reset_data_a", any_data, 64'h0);

      // Routing and off-mesh redirect table
      for (int v = 0; v < 15; v++) begin
         send(vecs[v].dut, vecs[v].src, vecs[v].dx, vecs[v].dy, vecs[v].exp_port,
              1'b1, 1'b1, $urandom);
         step();
         clear();
         for (int k = 1; k < LAT; k++) step();
         exp_vec = 5'b1 << vecs[v].exp_port;
         if (vecs[v].dut == 0) check($sformatf("route_vec%0d", v), 64'(pk(o_data_val)), 64'(exp_vec));
         else                  check($sformatf("route_vec%0d", v), 64'(pk(b_o_data_val)), 64'(exp_vec));
         step();
      end
      drain(10);

      // Backpressure on east
      i_en[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_o_en_%0d", i), 64'(o_en[0]), 64'(i < (OUTREG ? 5 : 4)));
         send(0, 0, 3, 1, 2, i < (OUTREG ? 5 : 4), 1'b0, $urandom);
         step();
      end
      clear();
      check("bp_full_o_en", 64'(o_en[0]), 64'h0);
      check("bp_hold_val", 64'(o_data_val[2]), 64'(OUTREG));
      i_en[2] = 1'b1;
      step();
      check("bp_reopen_o_en", 64'(o_en[0]), 64'h1);
      drain(20);

      // Fairness: north, south, west stream to east
      sb_on = 1'b0;
      fair_on = 1'b1;
      for (int i = 0; i < 34; i++) begin
         send(0, 1, 3, 1, 2, 1'b0, 1'b0, 32'd1);
         send(0, 3, 3, 1, 2, 1'b0, 1'b0, 32'd3);
         send(0, 4, 3, 1, 2, 1'b0, 1'b0, 32'd4);
         step();
      end
      clear();
      fair_on = 1'b0;
      for (int i = 0; i < 24; i++) step();
      sb_on = 1'b1;
      check("fair_len", 64'(fair_src.size() >= 30), 64'h1);
      win = (fair_src.size() < 30) ? fair_src.size() : 30;
      n1 = 0; n3 = 0; n4 = 0; rot_err = 0; prev = -1;
      for (int i = 0; i < win; i++) begin
         if (fair_src[i] == 1) n1++;
         else if (fair_src[i] == 3) n3++;
         else if (fair_src[i] == 4) n4++;
         if (prev >= 0) begin
            nxt = (prev == 1) ? 3 : (prev == 3) ? 4 : 1;
            if (fair_src[i] != nxt) rot_err++;
         end
         prev = fair_src[i];
      end
      check("fair_rotation_errors", 64'(rot_err), 64'h0);
      check("fair_north_share", 64'(n1 >= 9 && n1 <= 11), 64'h1);
      check("fair_south_share", 64'(n3 >= 9 && n3 <= 11), 64'h1);
      check("fair_west_share", 64'(n4 >= 9 && n4 <= 11), 64'h1);

      // Parallel transfers through the crossbar
      send(0, 0, 3, 1, 2, 1'b1, 1'b1, $urandom);
      send(0, 2, 0, 1, 4, 1'b1, 1'b1, $urandom);
      send(0, 1, 1, 3, 3, 1'b1, 1'b1, $urandom);
      send(0, 3, 1, 1, 0, 1'b1, 1'b1, $urandom);
      step();
      clear();
      for (int k = 1; k < LAT; k++) step();
      check("parallel_valid", 64'(pk(o_data_val)), 64'h1d);
      drain(10);

      // Reset with packets buffered: nothing may survive
      i_en[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(0, 0, 3, 1, 2, 1'b0, 1'b0, $urandom);
         step();
      end
      clear();
      reset = 1'b1;
      step();
      check("midreset_val", 64'(pk(o_data_val)), 64'h0);
      check("midreset_o_en", 64'(pk(o_en)), 64'h0);
      reset = 1'b0;
      step();
      check("midreset_release_o_en", 64'(pk(o_en)), 64'h1f);
      i_en[2] = 1'b1;
      for (int i = 0; i < 8; i++) step();

      for (int p = 0; p < 5; p++) begin
         check($sformatf("sb_left_a_port%0d", p), 64'(sbq_a[p].size()), 64'h0);
         check($sformatf("sb_left_b_port%0d", p), 64'(sbq_b[p].size()), 64'h0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
